// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith/compare ops,
// iterative one-bit-per-cycle shifter, valid/ready on both sides.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic [3:0]         ALUCtrl,
    input  logic [WIDTH-1:0]   OpA,
    input  logic [WIDTH-1:0]   OpB,
    input  logic [SHAMT_W-1:0] ShAmt,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH-1:0]   Result,
    output logic               Zero,
    output logic               Overflow,
    output logic               IllegalOp
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sop_t;

    state_t               state_q, state_d;
    sop_t                 sop_q, sop_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 ill_q, ill_d;

    logic [WIDTH-1:0]     sum, diff, alu_res, shf;
    logic                 alu_ovf, alu_ill, alu_shift;
    sop_t                 alu_sop;

    assign sum  = OpA + OpB;
    assign diff = OpA - OpB;

    // Decode the op and compute the single-cycle result
    always_comb begin
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        alu_shift = 1'b0;
        alu_sop   = SH_LL;
        unique case (ALUCtrl)
            4'b0000: alu_res = OpA & OpB;
            4'b0001: alu_res = OpA | OpB;
            4'b0010: begin
                alu_res = sum;
                alu_ovf = (OpA[WIDTH-1] == OpB[WIDTH-1]) &&
                          (sum[WIDTH-1] != OpA[WIDTH-1]);
            end
            4'b0011: begin
                alu_res   = OpA;
                alu_shift = 1'b1;
                alu_sop   = SH_LL;
            end
            4'b0100: begin
                alu_res   = OpA;
                alu_shift = 1'b1;
                alu_sop   = SH_RL;
            end
            4'b0110: begin
                alu_res = diff;
                alu_ovf = (OpA[WIDTH-1] != OpB[WIDTH-1]) &&
                          (diff[WIDTH-1] != OpA[WIDTH-1]);
            end
            4'b0111: alu_res = {{(WIDTH-1){1'b0}},
                                ($signed(OpA) < $signed(OpB))};
            4'b1000: alu_res = sum;
            4'b1001: alu_res = diff;
            4'b1010: alu_res = OpA ^ OpB;
            4'b1011: alu_res = {{(WIDTH-1){1'b0}}, (OpA < OpB)};
            4'b1100: alu_res = ~(OpA | OpB);
            4'b1101: begin
                alu_res   = OpA;
                alu_shift = 1'b1;
                alu_sop   = SH_RA;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // One-bit step of the iterative shifter
    always_comb begin
        shf = work_q;
        unique case (sop_q)
            SH_LL:   shf = {work_q[WIDTH-2:0], 1'b0};
            SH_RL:   shf = {1'b0, work_q[WIDTH-1:1]};
            SH_RA:   shf = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shf = work_q;
        endcase
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d  = state_q;
        sop_d    = sop_q;
        res_d    = res_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        InReady  = (state_q == S_IDLE);
        OutValid = (state_q == S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    if (alu_ill) begin
                        res_d   = '0;
                        zero_d  = 1'b1;
                        ovf_d   = 1'b0;
                        ill_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (alu_shift && (ShAmt != '0)) begin
                        work_d  = OpA;
                        cnt_d   = ShAmt;
                        sop_d   = alu_sop;
                        state_d = S_SHIFT;
                    end else begin
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        ovf_d   = alu_ovf;
                        ill_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shf;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    res_d   = shf;
                    zero_d  = (shf == '0);
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (OutReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            sop_q   <= SH_LL;
            res_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sop_q   <= sop_d;
            res_q   <= res_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    assign Result    = res_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign IllegalOp = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases, random ops,
// backpressure and mid-shift reset abort.
module tb_alu_exec_unit;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        i;
        int          lat;
        int          acc;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic [3:0]  ALUCtrl;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic [4:0]  ShAmt;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Result;
    logic        Zero;
    logic        Overflow;
    logic        IllegalOp;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   seen  = 0;
    exp_t sbq[$];

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .InValid(InValid), .InReady(InReady),
        .ALUCtrl(ALUCtrl), .OpA(OpA), .OpB(OpB), .ShAmt(ShAmt),
        .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Zero(Zero),
        .Overflow(Overflow), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc = cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [4:0] s);
        exp_t e;
        e.res = 0; e.o = 0; e.i = 0; e.lat = 1; e.acc = 0;
        case (c)
            4'h0: e.res = a & b;
            4'h1: e.res = a | b;
            4'h2: begin
                e.res = a + b;
                e.o = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            4'h3: e.res = a << s;
            4'h4: e.res = a >> s;
            4'h6: begin
                e.res = a - b;
                e.o = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            4'h7: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8: e.res = a + b;
            4'h9: e.res = a - b;
            4'hA: e.res = a ^ b;
            4'hB: e.res = (a < b) ? 32'd1 : 32'd0;
            4'hC: e.res = ~(a | b);
            4'hD: e.res = $unsigned($signed(a) >>> s);
            default: e.i = 1;
        endcase
        if ((c == 4'h3 || c == 4'h4 || c == 4'hD) && s != 0)
            e.lat = int'(s) + 1;
        e.z = (e.res == 0);
        return e;
    endfunction

    // Drive one request, push its expectation when it is accepted
    task automatic issue(input logic [3:0] c,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] s,
                         input exp_t e);
        int n;
        @(posedge Clk); #1;
        InValid = 1; ALUCtrl = c; OpA = a; OpB = b; ShAmt = s;
        n = 0;
        forever begin
            @(negedge Clk);
            if (InReady) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                InValid = 0;
                return;
            end
        end
        e.acc = cyc;
        sbq.push_back(e);
        @(posedge Clk); #1;
        InValid = 0;
    endtask

    task automatic issue_m(input logic [3:0] c,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [4:0] s);
        issue(c, a, b, s, model(c, a, b, s));
    endtask

    task automatic issue_d(input logic [3:0] c,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [4:0] s,
                           input logic [31:0] r,
                           input logic z, input logic o,
                           input logic i, input int lat);
        exp_t e;
        e.res = r; e.z = z; e.o = o; e.i = i;
        e.lat = lat; e.acc = 0;
        issue(c, a, b, s, e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0) begin
            @(negedge Clk);
            n++;
            if (n > 200) begin
                chk("drain_timeout", 0, 1);
                sbq.delete();
                seen = 0;
                return;
            end
        end
    endtask

    // Compare the head expectation when a result appears
    always @(negedge Clk) begin
        if (Rst_n && OutValid) begin
            if (sbq.size() == 0) begin
                chk("spurious_valid", 32'(OutValid), 0);
            end else begin
                if (!seen) begin
                    chk("result", Result, sbq[0].res);
                    chk("zero", 32'(Zero), 32'(sbq[0].z));
                    chk("ovf", 32'(Overflow), 32'(sbq[0].o));
                    chk("illegal", 32'(IllegalOp), 32'(sbq[0].i));
                    chk("latency", 32'(cyc - sbq[0].acc),
                        32'(sbq[0].lat));
                    seen = 1;
                end
                if (OutReady) begin
                    void'(sbq.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        int vbad;
        logic [3:0] rc;
        logic [4:0] rs;
        Rst_n = 0; InValid = 0; ALUCtrl = 0;
        OpA = 0; OpB = 0; ShAmt = 0; OutReady = 1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_inready", 32'(InReady), 1);
        chk("rst_outvalid", 32'(OutValid), 0);
        chk("rst_result", Result, 0);
        chk("rst_flags", {29'd0, Zero, Overflow, IllegalOp}, 0);
        Rst_n = 1;

        issue_d(4'h2, 32'h7FFF_FFFF, 32'h1, 0,
                32'h8000_0000, 0, 1, 0, 1);
        issue_d(4'h9, 32'd5, 32'd5, 0, 32'h0, 1, 0, 0, 1);
        issue_d(4'h7, 32'hFFFF_FFFF, 32'h1, 0, 32'h1, 0, 0, 0, 1);
        issue_d(4'hB, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1, 0, 0, 1);
        issue_d(4'hD, 32'h8000_0000, 0, 5'd4,
                32'hF800_0000, 0, 0, 0, 5);
        issue_d(4'h3, 32'h1234, 0, 5'd0, 32'h1234, 0, 0, 0, 1);
        issue_d(4'hF, 32'h55, 32'h66, 0, 32'h0, 1, 0, 1, 1);
        issue_d(4'h0, 32'hF0F0, 32'h0FF0, 0, 32'h00F0, 0, 0, 0, 1);
        issue_d(4'h6, 32'h8000_0000, 32'h1, 0,
                32'h7FFF_FFFF, 0, 1, 0, 1);
        issue_d(4'h3, 32'h1, 0, 5'd31, 32'h8000_0000, 0, 0, 0, 32);
        issue_d(4'h4, 32'h8000_0000, 0, 5'd31, 32'h1, 0, 0, 0, 32);
        issue_d(4'h5, 32'h1, 32'h1, 0, 32'h0, 1, 0, 1, 1);
        issue_d(4'hC, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0, 0, 0, 1);
        drain();

        for (int k = 0; k < 40; k++) begin
            rc = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 3) == 0) ? 5'd0
                 : 5'($urandom_range(1, 31));
            issue_m(rc, $urandom, $urandom, rs);
        end
        drain();

        OutReady = 0;
        issue_d(4'hA, 32'hFF00, 32'h0FF0, 0, 32'hF0F0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            InValid = 1; ALUCtrl = 4'h1;
            OpA = 32'hDEAD; OpB = 32'hBEEF;
            @(negedge Clk);
            chk("bp_valid", 32'(OutValid), 1);
            chk("bp_result", Result, 32'hF0F0);
            chk("bp_inready", 32'(InReady), 0);
        end
        @(posedge Clk); #1;
        InValid = 0; OutReady = 1;
        drain();
        issue_d(4'h8, 32'd1, 32'd2, 0, 32'd3, 0, 0, 0, 1);
        drain();

        issue_m(4'h4, 32'hFFFF_FFFF, 0, 5'd20);
        repeat (6) @(posedge Clk);
        #1;
        Rst_n = 0;
        #1;
        chk("abort_inready", 32'(InReady), 1);
        chk("abort_outvalid", 32'(OutValid), 0);
        chk("abort_result", Result, 0);
        chk("abort_flags", {29'd0, Zero, Overflow, IllegalOp}, 0);
        sbq.delete();
        seen = 0;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1;
        vbad = 0;
        repeat (30) begin
            @(negedge Clk);
            if (OutValid) vbad++;
        end
        chk("abort_no_valid", 32'(vbad), 0);

        issue_m(4'h0, 32'hCAFE_F00D, 32'h0F0F_0F0F, 0);
        issue_m(4'hD, 32'h4000_0000, 0, 5'd3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
